display_ctrl: RTL and testbench
===============================

// Module: display_ctrl
// PURPOSE
//  Configuration and sequencing controller for the six-digit multiplexed 7-seg display.
//  Holds six segment registers plus enable and blink masks, written over a req/ack port.
//  Drives the scanner's digit5..digit0 and disp_enable inputs.
//  Also generates the scanner's scan-rate tick, per-digit blink and PWM brightness gating.
// PARAMETERS
//  SCAN_DIV     1000  clk cycles per scan_tick pulse (>=2)
//  BLINK_TICKS  250   scan_tick pulses per blink half-period (>=1)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-high reset
//  wr_req       in   1  write request; held high by requester until wr_ack seen
//  wr_addr      in   3  0-5 = digit0..digit5 segs, 6 = enable mask, 7 = blink mask
//  wr_data      in   8  write data; masks use [5:0], [7:6] ignored
//  wr_ack       out  1  one-cycle write acknowledge
//  bright       in   3  brightness: digits lit for (bright+1)/8 of clk cycles
//  digit0..5    out  8  segment patterns to scanner, active high
//  disp_enable  out  6  per-digit enable to scanner, active high
//  scan_tick    out  1  one-cycle pulse every SCAN_DIV clks; scanner clock enable
//  blink_phase  out  1  1 = blinking digits currently blanked
// BEHAVIOUR
//  Reset (reset=1 at posedge): digitN=8'h00, en_mask=6'h3F, blink_mask=6'h00, wr_ack=0,
//   scan_tick=0, blink_phase=0, disp_enable=6'h00, all counters 0, FSM=IDLE.
//  Write FSM: IDLE -> ACK -> HOLD -> IDLE.
//   IDLE: wr_req=1 -> ACK. ACK (1 cycle): wr_ack=1; register written at the edge entering ACK,
//   so new value is visible on outputs while wr_ack=1. ACK -> HOLD unconditionally.
//   HOLD: wait for wr_req=0, then IDLE. A held wr_req never produces a second ack.
//   wr_addr/wr_data sampled on the IDLE->ACK edge only; later changes ignored.
//  Scan prescaler: scnt counts 0..SCAN_DIV-1, wraps to 0; scan_tick=1 in the cycle after
//   scnt==SCAN_DIV-1, so the first pulse is at clk SCAN_DIV after reset release, period SCAN_DIV.
//  Blink: bcnt counts scan_tick pulses 0..BLINK_TICKS-1. On the pulse that wraps bcnt,
//   blink_phase toggles. A full blink period is 2*BLINK_TICKS*SCAN_DIV clks.
//  PWM: 3-bit pcnt increments every clk and wraps 7->0. pwm_on = (pcnt <= bright).
//   bright=7 -> always on; bright=0 -> 1 of 8 cycles.
//  disp_enable[i] is registered, 1-cycle latency from its inputs:
//   en_mask[i] & pwm_on & ~(blink_mask[i] & blink_phase).
//  Writes to masks and bright changes affect disp_enable on the next edge.
//   They do not reset scnt, bcnt or pcnt.
//  Reset mid-handshake: FSM returns to IDLE, wr_ack=0.
//   If wr_req is still high after reset, it is treated as a new request.
// TESTING
//  1 Reset: assert reset 2 clks -> digits 0x00, wr_ack=0, disp_enable=0x00,
//    then disp_enable=0x3F on cycles where pwm_on=1 (bright=7 -> constant 0x3F).
//  2 Write: wr_addr=2, wr_data=0x5B, wr_req held 5 clks -> wr_ack high exactly 1 clk
//    (edge after req seen), digit2=0x5B from that cycle, other digits unchanged.
//  3 Back-to-back: drop wr_req 1 clk after ack, then write addr 6 data 0x05
//    -> second ack; disp_enable=0x05 at bright=7.
//  4 SCAN_DIV=4, BLINK_TICKS=2, blink_mask=0x01, en_mask=0x3F, bright=7
//    -> scan_tick every 4 clks; blink_phase toggles every 8 clks;
//    disp_enable alternates 0x3F/0x3E.
//  5 bright=3, en_mask=0x3F -> disp_enable=0x3F for exactly 4 of every 8 clks;
//    bright=0 -> 1 of 8.
//  6 Assert reset while FSM is in ACK with wr_req high -> wr_ack=0 next clk;
//    written data lost (digit reset to 0x00); after reset release a single new ack follows.

Source files
------------

// File: rtl/display_ctrl.sv
// display_ctrl: configuration and sequencing controller for a six-digit
// multiplexed 7-segment display. It holds the segment registers and the
// enable/blink masks, which are written over a req/ack port. It also produces
// the scanner clock enable, the blink phase and the PWM brightness gating.
module display_ctrl #(
  parameter int SCAN_DIV    = 1000,  // clk cycles per scan_tick pulse (>=2)
  parameter int BLINK_TICKS = 250    // scan_tick pulses per blink half-period (>=1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_req,
  input  logic [2:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_ack,
  input  logic [2:0] i_bright,
  output logic [7:0] o_digit0,
  output logic [7:0] o_digit1,
  output logic [7:0] o_digit2,
  output logic [7:0] o_digit3,
  output logic [7:0] o_digit4,
  output logic [7:0] o_digit5,
  output logic [5:0] o_disp_enable,
  output logic       o_scan_tick,
  output logic       o_blink_phase
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_t;

  wr_state_t          r_state;
  logic               r_wr_ack;
  logic [7:0]         r_digit [6];
  logic [5:0]         r_en_mask;
  logic [5:0]         r_blink_mask;
  logic [SCAN_W-1:0]  r_scnt;
  logic               r_scan_tick;
  logic [BLINK_W-1:0] r_bcnt;
  logic               r_blink_phase;
  logic [2:0]         r_pcnt;
  logic [5:0]         r_disp_enable;

  logic               w_pwm_on;
  logic [5:0]         w_blank;
  logic [5:0]         w_disp_enable_nxt;

  // PWM gate and per-digit blanking feeding the registered enable
  assign w_pwm_on          = (r_pcnt <= i_bright);
  assign w_blank           = r_blink_mask & {6{r_blink_phase}};
  assign w_disp_enable_nxt = r_en_mask & {6{w_pwm_on}} & ~w_blank;

  // Write handshake FSM; the register file is written on the IDLE->ACK edge only,
  // so a held request or later changes to addr/data never cause a second write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_wr_ack     <= 1'b0;
      r_en_mask    <= 6'h3F;
      r_blink_mask <= 6'h00;
      for (int i = 0; i < 6; i++) begin
        r_digit[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_wr_req) begin
            r_state  <= ST_ACK;
            r_wr_ack <= 1'b1;
            case (i_wr_addr)
              3'd0:    r_digit[0]   <= i_wr_data;
              3'd1:    r_digit[1]   <= i_wr_data;
              3'd2:    r_digit[2]   <= i_wr_data;
              3'd3:    r_digit[3]   <= i_wr_data;
              3'd4:    r_digit[4]   <= i_wr_data;
              3'd5:    r_digit[5]   <= i_wr_data;
              3'd6:    r_en_mask    <= i_wr_data[5:0];
              3'd7:    r_blink_mask <= i_wr_data[5:0];
              default: r_en_mask    <= r_en_mask;
            endcase
          end else begin
            r_wr_ack <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state  <= ST_HOLD;
          r_wr_ack <= 1'b0;
        end
        ST_HOLD: begin
          r_wr_ack <= 1'b0;
          if (!i_wr_req) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wr_ack <= 1'b0;
        end
      endcase
    end
  end

  // Scan prescaler: scan_tick pulses in the cycle after scnt reaches its last value
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scnt      <= {SCAN_W{1'b0}};
      r_scan_tick <= 1'b0;
    end else if (r_scnt == SCAN_LAST) begin
      r_scnt      <= {SCAN_W{1'b0}};
      r_scan_tick <= 1'b1;
    end else begin
      r_scnt      <= r_scnt + SCAN_W'(1);
      r_scan_tick <= 1'b0;
    end
  end

  // Blink divider: counts scan ticks and flips the phase each time it wraps
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcnt        <= {BLINK_W{1'b0}};
      r_blink_phase <= 1'b0;
    end else if (r_scan_tick) begin
      if (r_bcnt == BLINK_LAST) begin
        r_bcnt        <= {BLINK_W{1'b0}};
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_bcnt <= r_bcnt + BLINK_W'(1);
      end
    end else begin
      r_bcnt <= r_bcnt;
    end
  end

  // Free-running 3-bit PWM counter that sets brightness duty in eighths
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pcnt <= 3'd0;
    end else begin
      r_pcnt <= r_pcnt + 3'd1;
    end
  end

  // Registered per-digit enable so the scanner sees glitch-free gating
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_disp_enable <= 6'h00;
    end else begin
      r_disp_enable <= w_disp_enable_nxt;
    end
  end

  assign o_wr_ack      = r_wr_ack;
  assign o_digit0      = r_digit[0];
  assign o_digit1      = r_digit[1];
  assign o_digit2      = r_digit[2];
  assign o_digit3      = r_digit[3];
  assign o_digit4      = r_digit[4];
  assign o_digit5      = r_digit[5];
  assign o_disp_enable = r_disp_enable;
  assign o_scan_tick   = r_scan_tick;
  assign o_blink_phase = r_blink_phase;

endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: directed bench for display_ctrl built with SCAN_DIV=4, BLINK_TICKS=2.
module tb_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [2:0] bright;
  logic [7:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic [5:0] disp_enable;
  logic       scan_tick;
  logic       blink_phase;
  logic [7:0] dig [6];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // clock edges since the last edge that sampled reset high

  logic [7:0] m_dig [6];
  logic [5:0] m_en;
  logic [5:0] m_blink;

  display_ctrl #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_wr_req      (wr_req),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_ack      (wr_ack),
    .i_bright      (bright),
    .o_digit0      (digit0),
    .o_digit1      (digit1),
    .o_digit2      (digit2),
    .o_digit3      (digit3),
    .o_digit4      (digit4),
    .o_digit5      (digit5),
    .o_disp_enable (disp_enable),
    .o_scan_tick   (scan_tick),
    .o_blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  assign dig[0] = digit0;
  assign dig[1] = digit1;
  assign dig[2] = digit2;
  assign dig[3] = digit3;
  assign dig[4] = digit4;
  assign dig[5] = digit5;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1ns later, inputs change at the same point
  task automatic step();
    logic rs;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs) cyc = 0;
    else    cyc++;
  endtask

  function automatic logic exp_tick(input int n);
    return (n != 0) && (n % 4 == 0);
  endfunction

  function automatic logic exp_phase(input int n);
    if (n == 0) return 1'b0;
    return (((n - 1) / 8) % 2) == 1;
  endfunction

  // disp_enable after edge n uses pcnt, phase and masks as they were before that edge
  function automatic logic [5:0] exp_de(input int n);
    logic on;
    logic ph;
    if (n == 0) return 6'h00;
    on = (((n - 1) % 8) <= int'(bright));
    ph = exp_phase(n - 1);
    return m_en & {6{on}} & ~(m_blink & {6{ph}});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_dig[i] = 8'h00;
    m_en    = 6'h3F;
    m_blink = 6'h00;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a < 3'd6)       m_dig[a] = d;
    else if (a == 3'd6) m_en = d[5:0];
    else                m_blink = d[5:0];
  endtask

  task automatic check_digits(input string tag);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("%s_digit%0d", tag, i), 32'(dig[i]), 32'(m_dig[i]));
  endtask

  task automatic check_timing(input string tag);
    check_eq($sformatf("%s_tick_c%0d", tag, cyc), 32'(scan_tick), 32'(exp_tick(cyc)));
    check_eq($sformatf("%s_phase_c%0d", tag, cyc), 32'(blink_phase), 32'(exp_phase(cyc)));
    check_eq($sformatf("%s_de_c%0d", tag, cyc), 32'(disp_enable), 32'(exp_de(cyc)));
  endtask

  // Write with wr_req dropped right after the ack; ends back in IDLE
  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    step();
    check_eq($sformatf("wr%0d_ack_rise", a), 32'(wr_ack), 32'd1);
    model_write(a, d);
    check_digits($sformatf("wr%0d", a));
    wr_req = 1'b0;
    step();
    check_eq($sformatf("wr%0d_ack_fall", a), 32'(wr_ack), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int lit;
    reset   = 1'b1;
    wr_req  = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'h00;
    bright  = 3'd7;
    model_reset();

    // Reset held two clocks, then constant 0x3F at full brightness
    step();
    step();
    check_digits("rst");
    check_eq("rst_ack", 32'(wr_ack), 32'd0);
    check_eq("rst_de", 32'(disp_enable), 32'h00);
    check_eq("rst_tick", 32'(scan_tick), 32'd0);
    check_eq("rst_phase", 32'(blink_phase), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_timing("post_rst");
    end
    check_eq("post_rst_de3f", 32'(disp_enable), 32'h3F);

    // Write digit2 with wr_req held for five clocks: exactly one ack
    wr_addr = 3'd2;
    wr_data = 8'h5B;
    wr_req  = 1'b1;
    acks    = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        check_eq("held_ack_first", 32'(wr_ack), 32'd1);
        model_write(3'd2, 8'h5B);
        check_digits("held");
      end
      if (i == 1) check_eq("held_ack_second", 32'(wr_ack), 32'd0);
      acks += int'(wr_ack);
    end
    check_eq("held_ack_count", 32'(acks), 32'd1);
    wr_req = 1'b0;
    step();
    step();
    check_digits("held_after");

    // Back-to-back writes; enable mask 0x05 shows on disp_enable at bright=7
    do_write(3'd0, 8'h3F);
    do_write(3'd6, 8'h05);
    for (int i = 0; i < 8; i++) begin
      step();
      check_timing("en05");
    end
    check_eq("en05_de", 32'(disp_enable), 32'h05);

    // Blink digit0: scan_tick every 4, phase every 8, enable 0x3F/0x3E
    do_write(3'd6, 8'h3F);
    do_write(3'd7, 8'h01);
    for (int i = 0; i < 24; i++) begin
      step();
      check_timing("blink");
    end

    // PWM duty: bright=3 -> 4 of 8 cycles, bright=0 -> 1 of 8
    do_write(3'd7, 8'h00);
    bright = 3'd3;
    lit    = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_timing("pwm3");
      if (disp_enable == 6'h3F) lit++;
    end
    check_eq("pwm3_lit", 32'(lit), 32'd8);
    bright = 3'd0;
    lit    = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_timing("pwm0");
      if (disp_enable == 6'h3F) lit++;
    end
    check_eq("pwm0_lit", 32'(lit), 32'd2);
    bright = 3'd7;

    // Reset while in ACK with wr_req high: write lost, one fresh ack after release
    wr_addr = 3'd1;
    wr_data = 8'h66;
    wr_req  = 1'b1;
    step();
    check_eq("midrst_ack_rise", 32'(wr_ack), 32'd1);
    model_write(3'd1, 8'h66);
    check_digits("midrst_pre");
    reset = 1'b1;
    step();
    model_reset();
    check_eq("midrst_ack_clr", 32'(wr_ack), 32'd0);
    check_digits("midrst_clr");
    check_eq("midrst_de", 32'(disp_enable), 32'h00);
    reset = 1'b0;
    acks  = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        check_eq("midrst_new_ack", 32'(wr_ack), 32'd1);
        model_write(3'd1, 8'h66);
      end
      acks += int'(wr_ack);
      check_timing("midrst");
    end
    check_eq("midrst_ack_count", 32'(acks), 32'd1);
    wr_req = 1'b0;
    step();
    step();
    check_digits("midrst_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
